// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and width helpers for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {SYNC, HOLD, REL, RUN} state_e;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: async-assert / sync-deassert reset synchronizer
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);
  logic [STAGES-1:0] sync_q;
  // shift ones in after release; any rst_n low clears the whole chain at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= (sync_q << 1) | STAGES'(1);
  assign rst_sync_n = sync_q[STAGES-1];
endmodule

// File: rtl/reset_domain_sequencer.sv
// reset_domain_sequencer: ordered, gap-spaced release of N domain resets with runtime sw re-reset
module reset_domain_sequencer import reset_seq_pkg::*; #(
  parameter int N_DOMAINS   = 4,
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [GAP_W-1:0]     gap_cfg,
  input  logic                 sw_rst_req,
  input  logic [N_DOMAINS-1:0] sw_rst_mask,
  output logic                 sw_rst_ack,
  output logic [N_DOMAINS-1:0] domain_rst_n,
  output logic                 busy,
  output logic                 done
);
  localparam int HW = cnt_w(HOLD_CYCLES + 1);
  localparam int IW = cnt_w(N_DOMAINS);
  state_e               state_q;
  logic [HW-1:0]        hold_q;
  logic [GAP_W-1:0]     gap_q, gcnt_q;
  logic [N_DOMAINS-1:0] rem_q, rem_d, rst_n_q;
  logic [IW-1:0]        rel_idx;
  logic                 sw_q, busy_q, done_q, ack_q, rst_sync_n, rel;
  // the SYNC state register acts as the final synchronizer stage, so the chain is one shorter
  reset_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );
  // lowest still-held selected domain; unselected ones are never visited
  always_comb begin
    rel_idx = '0;
    for (int i = N_DOMAINS - 1; i >= 0; i--) if (rem_q[i]) rel_idx = IW'(i);
  end
  assign rem_d = rem_q & ~(N_DOMAINS'(1) << rel_idx);
  assign rel   = gcnt_q == gap_q;
  // sequencing FSM; in SYNC nothing but the state can change, so release near clk is harmless
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= SYNC;
      hold_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      rem_q   <= '0;
      rst_n_q <= '0;
      sw_q    <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        SYNC: if (rst_sync_n) begin
          state_q <= HOLD;
          hold_q  <= '0;
          gap_q   <= gap_cfg;
          rem_q   <= '1;
          sw_q    <= 1'b0;
        end
        HOLD: if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_q <= REL;
          gcnt_q  <= gap_q;
        end else hold_q <= hold_q + HW'(1);
        REL: begin
          if (rel) begin
            rst_n_q <= rst_n_q | (rem_q ^ rem_d);
            rem_q   <= rem_d;
            gcnt_q  <= '0;
          end else gcnt_q <= gcnt_q + GAP_W'(1);
          if (rel && rem_d == '0) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ack_q   <= sw_q;
          end
        end
        RUN: if (sw_rst_req) begin
          state_q <= (sw_rst_mask == '0) ? REL : HOLD;
          hold_q  <= '0;
          gap_q   <= gap_cfg;
          gcnt_q  <= gap_cfg;
          rem_q   <= sw_rst_mask;
          rst_n_q <= rst_n_q & ~sw_rst_mask;
          sw_q    <= 1'b1;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        default: state_q <= SYNC;
      endcase
    end
  assign domain_rst_n = rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sw_rst_ack   = ack_q;
endmodule

// File: tb/tb_reset_domain_sequencer.sv
// tb_reset_domain_sequencer: directed checks of power-on, sw re-reset and mid-sequence reset
module tb_reset_domain_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gap_cfg;
  logic       sw_rst_req;
  logic [3:0] sw_rst_mask;
  logic       sw_rst_ack;
  logic [3:0] domain_rst_n;
  logic       busy;
  logic       done;
  int         checks = 0;
  int         errors = 0;
  int         ack_cnt = 0;
  reset_domain_sequencer #(
    .N_DOMAINS(4), .SYNC_STAGES(3), .HOLD_CYCLES(4), .GAP_W(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gap_cfg      (gap_cfg),
    .sw_rst_req   (sw_rst_req),
    .sw_rst_mask  (sw_rst_mask),
    .sw_rst_ack   (sw_rst_ack),
    .domain_rst_n (domain_rst_n),
    .busy         (busy),
    .done         (done)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ack_cnt += int'(sw_rst_ack);
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] dom, input logic b, input logic d);
    chk({tag, ".dom"}, 32'(domain_rst_n), 32'(dom));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask
  initial begin
    rst_n = 1'b0; gap_cfg = 8'd2; sw_rst_req = 1'b0; sw_rst_mask = 4'h0;
    #23;
    chk_out("por_in_reset", 4'h0, 1'b1, 1'b0);
    chk("por_in_reset.ack", 32'(sw_rst_ack), 0);
    @(negedge clk) rst_n = 1'b1;
    tick(7);  chk_out("gap2_e7", 4'h0, 1'b1, 1'b0);
    tick(1);  chk_out("gap2_e8", 4'h1, 1'b1, 1'b0);
    tick(2);  chk_out("gap2_e10", 4'h1, 1'b1, 1'b0);
    tick(1);  chk_out("gap2_e11", 4'h3, 1'b1, 1'b0);
    tick(3);  chk_out("gap2_e14", 4'h7, 1'b1, 1'b0);
    tick(2);  chk_out("gap2_e16", 4'h7, 1'b1, 1'b0);
    tick(1);  chk_out("gap2_e17", 4'hF, 1'b0, 1'b1);
    chk("gap2_no_ack", 32'(ack_cnt), 0);
    rst_n = 1'b0; gap_cfg = 8'd0;
    #1 chk_out("async_assert_run", 4'h0, 1'b1, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick(7);  chk_out("gap0_e7", 4'h0, 1'b1, 1'b0);
    tick(1);  chk_out("gap0_e8", 4'h1, 1'b1, 1'b0);
    tick(1);  chk_out("gap0_e9", 4'h3, 1'b1, 1'b0);
    tick(1);  chk_out("gap0_e10", 4'h7, 1'b1, 1'b0);
    tick(1);  chk_out("gap0_e11", 4'hF, 1'b0, 1'b1);
    ack_cnt = 0; sw_rst_mask = 4'b1010; gap_cfg = 8'd1; sw_rst_req = 1'b1;
    tick(1);  chk_out("sw1010_s", 4'b0101, 1'b1, 1'b0);
    sw_rst_req = 1'b0; gap_cfg = 8'd9; sw_rst_mask = 4'hF;
    tick(4);  chk_out("sw1010_s4", 4'b0101, 1'b1, 1'b0);
    tick(1);  chk_out("sw1010_s5", 4'b0111, 1'b1, 1'b0);
    chk("sw1010_s5.ack", 32'(sw_rst_ack), 0);
    tick(1);  chk_out("sw1010_s6", 4'b0111, 1'b1, 1'b0);
    tick(1);  chk_out("sw1010_s7", 4'hF, 1'b0, 1'b1);
    chk("sw1010_s7.ack", 32'(sw_rst_ack), 1);
    tick(1);  chk("sw1010_s8.ack", 32'(sw_rst_ack), 0);
    chk("sw1010_ack_count", 32'(ack_cnt), 1);
    sw_rst_mask = 4'h0; sw_rst_req = 1'b1;
    tick(1);  chk_out("sw0_s", 4'hF, 1'b1, 1'b0);
    chk("sw0_s.ack", 32'(sw_rst_ack), 0);
    tick(1);  chk_out("sw0_s1", 4'hF, 1'b0, 1'b1);
    chk("sw0_s1.ack", 32'(sw_rst_ack), 1);
    tick(1);  chk_out("sw0_rerun_s2", 4'hF, 1'b1, 1'b0);
    chk("sw0_rerun_s2.ack", 32'(sw_rst_ack), 0);
    sw_rst_req = 1'b0;
    tick(1);  chk("sw0_rerun_s3.ack", 32'(sw_rst_ack), 1);
    tick(1);  chk_out("sw0_idle", 4'hF, 1'b0, 1'b1);
    chk("sw0_idle.ack", 32'(sw_rst_ack), 0);
    rst_n = 1'b0; gap_cfg = 8'd2;
    @(negedge clk) rst_n = 1'b1;
    tick(11); chk_out("midrel_e11", 4'h3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("midrel_async", 4'h0, 1'b1, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick(8);  chk_out("midrel_por_e8", 4'h1, 1'b1, 1'b0);
    tick(3);  chk_out("midrel_por_e11", 4'h3, 1'b1, 1'b0);
    tick(3);  chk_out("midrel_por_e14", 4'h7, 1'b1, 1'b0);
    tick(3);  chk_out("midrel_por_e17", 4'hF, 1'b0, 1'b1);
    rst_n = 1'b0; gap_cfg = 8'd1; sw_rst_req = 1'b1; sw_rst_mask = 4'b0001;
    @(negedge clk) rst_n = 1'b1;
    ack_cnt = 0;
    tick(5);  chk_out("holdreq_e5", 4'h0, 1'b1, 1'b0);
    gap_cfg = 8'd5;
    tick(3);  chk_out("holdreq_e8", 4'h1, 1'b1, 1'b0);
    tick(2);  chk_out("holdreq_e10", 4'h3, 1'b1, 1'b0);
    tick(2);  chk_out("holdreq_e12", 4'h7, 1'b1, 1'b0);
    tick(2);  chk_out("holdreq_e14", 4'hF, 1'b0, 1'b1);
    chk("holdreq_no_ack", 32'(ack_cnt), 0);
    tick(1);  chk_out("holdreq_accept", 4'hE, 1'b1, 1'b0);
    sw_rst_req = 1'b0;
    tick(4);  chk_out("holdreq_s4", 4'hE, 1'b1, 1'b0);
    tick(1);  chk_out("holdreq_s5", 4'hF, 1'b0, 1'b1);
    chk("holdreq_s5.ack", 32'(sw_rst_ack), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reset_domain_sequencer.md
Name: reset_domain_sequencer

Overview:
- Central reset controller for a group of downstream reset domains.
- Takes one async active-low reset, synchronizes its deassertion, and releases N domain resets in ascending index order with a programmable gap between them.
- Lets a software/debug requester re-reset a masked subset of domains at runtime through a req/ack handshake.
- Every domain reset output asserts asynchronously and deasserts synchronously to clk, so downstream async-reset registers always see a clean release.

Parameters:
- N_DOMAINS, 4, number of domain reset outputs (1..16).
- SYNC_STAGES, 3, flops in the reset-deassertion synchronizer (>=2).
- HOLD_CYCLES, 4, cycles all selected domains stay asserted before the first release (>=1).
- GAP_W, 8, width of gap_cfg.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  async active-low reset. Asserts asynchronously; deassertion is synchronized internally.
- gap_cfg  in  GAP_W  extra cycles between consecutive domain releases. Sampled when a sequence starts.
- sw_rst_req  in  1  level request for a runtime reset of the masked domains.
- sw_rst_mask  in  N_DOMAINS  domains affected by sw_rst_req. Sampled when the request is accepted.
- sw_rst_ack  out  1  one-cycle pulse when the requested sequence completes.
- domain_rst_n  out  N_DOMAINS  per-domain active-low reset.
- busy  out  1  a sequence is in progress.
- done  out  1  all domains released; controller idle in RUN.

Behaviour:
- Interface decided: one clock, clk; reset rst_n is asynchronous and active-low. All state flops are async-cleared by rst_n.
- While rst_n is low:
  - domain_rst_n = all 0 immediately, no clock needed.
  - busy=1, done=0, sw_rst_ack=0.
  - state=SYNC, synchronizer cleared.
- rst_n-to-domain_rst_n assertion is purely combinational through async clear; no glitch-prone logic in that path.
- Domain release is always from a flop clocked by clk.
- States and transitions:
  - SYNC: wait for the synchronized reset to go high. Synchronizer output rises on edge SYNC_STAGES, counting the first edge with rst_n high as edge 1. The sequence start edge is SYNC_STAGES; latch gap_cfg and an all-ones mask, then go to HOLD.
  - HOLD: counter runs HOLD_CYCLES cycles. Selected domains stay low.
  - REL: release the lowest remaining selected domain.
    - Next selected domain is released gap_cfg+1 edges after the previous one.
    - Unselected domains are skipped and consume zero cycles.
    - After the last selected domain is released, go to RUN.
  - RUN: busy=0, done=1.
- Timing formulas (start edge s):
  - First selected domain releases on edge s+HOLD_CYCLES+1.
  - k-th selected domain (k from 0) releases on edge s+HOLD_CYCLES+1+k*(gap_cfg+1).
  - done rises and busy falls on the same edge as the final release.
- Software reset:
  - sw_rst_req is honoured only in RUN. Elsewhere it is ignored (not queued); the requester holds the level.
  - Acceptance edge s: latch sw_rst_mask and gap_cfg; masked domain_rst_n go to 0 on edge s; busy=1, done=0; go to HOLD.
  - Unmasked domains remain 1 throughout.
  - sw_rst_ack pulses high for one cycle on the final release edge.
  - If sw_rst_mask==0 at acceptance, there is no HOLD: ack pulses on edge s+1, nothing is asserted, busy is high for one cycle.
  - The requester must drop req in the cycle ack is seen. If req is still high on the edge after ack, a new sequence starts.
- Reset mid-operation: rst_n low in any state aborts immediately; all domains are asserted and the ack pulse is lost. Power-on sequence then follows.
- gap_cfg changes during a sequence have no effect. gap_cfg = all-ones is legal; no wrap in the gap counter.
- Counter widths: hold counter clog2(HOLD_CYCLES+1), gap counter GAP_W, domain index clog2(N_DOMAINS).
- Outputs are registered. sw_rst_ack is never asserted outside RUN entry.

Decomposition:
- Package reset_seq_pkg:
  - state enum {SYNC, HOLD, REL, RUN}
  - localparam helpers for counter widths
- Sub-module reset_sync: SYNC_STAGES-deep async-assert/sync-deassert synchronizer, ports clk, rst_n, rst_sync_n. Reusable elsewhere.

Test Plan:
- Power-on, N=4, SYNC=3, HOLD=4, gap_cfg=2 -> domain_rst_n bits 0..3 rise on edges 8, 11, 14, 17; done=1 and busy=0 on edge 17; sw_rst_ack never pulses.
- Power-on with gap_cfg=0 -> bits 0..3 rise on consecutive edges 8, 9, 10, 11.
- In RUN, req with mask=4'b1010, gap_cfg=1, accepted at edge s -> bits 1 and 3 fall on edge s; bit 1 rises on s+5, bit 3 on s+7; bits 0 and 2 stay 1; ack on s+7 only.
- req with mask=0 in RUN -> ack on s+1, domain_rst_n stays 4'b1111, busy high for one cycle; req held through ack -> second sequence starts on the next edge.
- rst_n pulsed low mid-REL after domain 1 released -> domain_rst_n=0 asynchronously before the next clk edge; full power-on sequence repeats with the original edge numbers.
- req asserted during the power-on HOLD and held -> ignored until RUN, accepted on the first edge in RUN; gap_cfg changed mid-sequence -> release spacing unchanged.
